// File: rtl/instruction_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch unit and its fetch FIFO:
// bus widths, PC step, the fetch FSM state type, the fetch-entry record and
// a PC alignment helper.
// ---------------------------------------------------------------------------
package instruction_fetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instructions are word aligned; the low two PC bits are always dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
    return {pc[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch entries {pc, instr}.
// Ports:
//   CLK, resetl  - clock, asynchronous active-low reset
//   i_push       - write i_entry (accepted when not full or popping)
//   i_pop        - advance head (ignored when empty)
//   i_clear      - synchronous flush, wins over push and pop
//   i_entry      - entry to write
//   o_full       - occupancy == DEPTH
//   o_empty      - occupancy == 0
//   o_head       - head entry, zero while empty
// ---------------------------------------------------------------------------
module fetch_fifo
  import instruction_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         resetl,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_clear,
  input  fetch_entry_t i_entry,
  output logic         o_full,
  output logic         o_empty,
  output fetch_entry_t o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == {CNT_W{1'b0}});
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Head is gated to zero while empty so no stale entry is ever presented.
  always_comb begin
    o_head = '0;
    if (!o_empty) begin
      o_head = r_mem[r_rd_ptr];
    end else begin
      o_head = '0;
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else if (i_clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Sequential fetch from a read-only instruction memory. Holds Address stable
// for WAIT_CYCLES cycles, captures Data with its PC into a small FIFO and
// presents the FIFO head to decode via InstrValid/InstrReady. Redirect
// flushes everything and restarts at RedirectPC (word aligned).
// Ports:
//   CLK, resetl      - clock, asynchronous active-low reset
//   Address  (out)   - registered fetch address
//   Data     (in)    - memory read data for Address
//   InstrOut (out)   - head instruction, InstrPC its PC
//   InstrValid (out) - FIFO non-empty
//   InstrReady (in)  - consumer takes head this cycle
//   Redirect (in)    - flush and restart at RedirectPC
// ---------------------------------------------------------------------------
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int                WAIT_CYCLES = 2,
  parameter int                DEPTH       = 2,
  parameter logic [ADDR_W-1:0] RESET_PC    = 64'h0
) (
  input  logic               CLK,
  input  logic               resetl,
  output logic [ADDR_W-1:0]  Address,
  input  logic [INSTR_W-1:0] Data,
  output logic [INSTR_W-1:0] InstrOut,
  output logic [ADDR_W-1:0]  InstrPC,
  output logic               InstrValid,
  input  logic               InstrReady,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  fetch_state_e      r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;

  logic         w_full;
  logic         w_empty;
  logic         w_pop;
  logic         w_space;
  logic         w_wait_done;
  logic         w_push;
  fetch_entry_t w_head;
  fetch_entry_t w_entry;

  assign w_pop       = !w_empty && InstrReady;
  assign w_space     = !w_full || w_pop;
  // In HOLD the counter is frozen at its last value, so this stays true.
  assign w_wait_done = (r_cnt == CNT_LAST);
  assign w_push      = !Redirect && w_wait_done && w_space;
  assign w_entry     = '{pc: r_addr, instr: Data};

  assign Address    = r_addr;
  assign InstrValid = !w_empty;
  assign InstrOut   = w_head.instr;
  assign InstrPC    = w_head.pc;

  // Fetch FSM: PC register, wait counter and FETCH/HOLD state.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= FETCH;
      r_cnt   <= {CNT_W{1'b0}};
      r_addr  <= RESET_PC;
    end else if (Redirect) begin
      r_state <= FETCH;
      r_cnt   <= {CNT_W{1'b0}};
      r_addr  <= align_pc(RedirectPC);
    end else begin
      case (r_state)
        FETCH: begin
          if (!w_wait_done) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (w_space) begin
            r_addr <= r_addr + PC_STEP;
            r_cnt  <= {CNT_W{1'b0}};
          end else begin
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (w_space) begin
            r_addr  <= r_addr + PC_STEP;
            r_cnt   <= {CNT_W{1'b0}};
            r_state <= FETCH;
          end else begin
            r_state <= HOLD;
          end
        end
        default: begin
          r_state <= FETCH;
          r_cnt   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK     (CLK),
    .resetl  (resetl),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (Redirect),
    .i_entry (w_entry),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Sequential instruction fetch unit: the reading side of the read-only instruction memory. It owns the program counter, drives the memory `Address` bus, and waits out the memory's read latency before capturing `Data`. Captured words, tagged with their PC, go into a small FIFO that a downstream decode stage drains through a valid/ready handshake. A redirect input (taken branch, CBZ, B) flushes in-flight and buffered work and restarts fetch at a new PC.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: clock cycles that `Address` must be held stable before `Data` is sampled. Minimum 1; sized to cover the memory's 20 ns read time.
- `DEPTH`, 2: fetch FIFO entries. Power of two, at least 2.
- `RESET_PC`, 64'h0: first fetch address after reset.

Ports:
- `CLK` in 1: single clock, rising edge.
- `resetl` in 1: asynchronous, active-low reset.
- `Address` out 64: registered fetch address to instruction memory.
- `Data` in 32: instruction word returned by memory.
- `InstrOut` out 32: head-of-FIFO instruction.
- `InstrPC` out 64: PC of `InstrOut`.
- `InstrValid` out 1: FIFO non-empty.
- `InstrReady` in 1: consumer accepts the head this cycle.
- `Redirect` in 1: one-cycle pulse that flushes and restarts fetch.
- `RedirectPC` in 64: new fetch PC, sampled when `Redirect` is 1.

## Operation
- Reset values: `Address`=`RESET_PC`, `InstrValid`=0, `InstrOut`=0, `InstrPC`=0, FIFO empty, wait counter `cnt`=0, state FETCH.
- State FETCH:
  - `cnt` increments each cycle while below `WAIT_CYCLES`-1.
  - When `cnt`==`WAIT_CYCLES`-1 and space exists, push {`Address`, `Data`}, set `Address`+=4, and set `cnt`=0.
  - Space exists when occupancy < `DEPTH`, or when a pop happens in the same cycle.
  - If `cnt`==`WAIT_CYCLES`-1 and there is no space, go to HOLD.
- State HOLD: `Address` and `cnt` are frozen, so `Data` stays valid. On the first cycle with space, push, set `Address`+=4, set `cnt`=0, and return to FETCH.
- Pop: occurs when `InstrValid` and `InstrReady` are both 1 at a rising edge; the head advances. `InstrReady` while empty has no effect.
- Redirect takes priority over push, pop and state. On that edge:
  - FIFO cleared.
  - `Address` set to {`RedirectPC`[63:2], 2'b00}; the low two bits are forced to zero.
  - `cnt` set to 0; state set to FETCH.
  - No push occurs.
  - A pop handshake in the same cycle counts as accepted by the consumer; the fetch unit simply flushes.
- Arithmetic: `Address`+4 is a 64-bit modulo add, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. There is no alignment fault.
- `Data` is sampled as-is. Undefined memory contents (unmapped addresses) pass through unchanged; decode handles them.
- An asynchronous reset mid-wait or mid-HOLD discards everything and restarts at `RESET_PC`.

## Timing
- Throughput is one instruction per `WAIT_CYCLES` cycles when the consumer is always ready. With `WAIT_CYCLES`=1 this is one per cycle.
- Latency, reset release to first `InstrValid`: `WAIT_CYCLES` rising edges.
- Latency, `Redirect` edge to first `InstrValid` from the new PC: `WAIT_CYCLES` further edges. `InstrValid` is 0 in the cycle after the redirect.
- All outputs are registered. There are no combinational paths from `InstrReady`, `Redirect` or `Data` to any output.
- Occupancy never exceeds `DEPTH`. A simultaneous push and pop while full keeps occupancy at `DEPTH`.

## Structure
- Shared package holds:
  - `ADDR_W`=64, `INSTR_W`=32, `PC_STEP`=4.
  - The state enum {FETCH, HOLD}.
  - A fetch-entry typedef {pc[63:0], instr[31:0]}.
- Sub-module `fetch_fifo`: synchronous FIFO of fetch entries with a `DEPTH` parameter, push, pop, clear, full, empty and head outputs. It uses the same `CLK`/`resetl`. `clear` is synchronous and takes priority over push and pop.
- The top level contains the PC register, the wait counter and the two-state FSM.

## Test plan
- Reset, `WAIT_CYCLES`=2, `InstrReady`=1 against the test-program memory. Require:
  - `Address` 0 → `InstrOut` F84003E9 / `InstrPC` 0 after 2 edges.
  - `Address` 4 → F84083EA / `InstrPC` 4 two edges later.
- `InstrReady`=0 for 10 cycles. Require:
  - Occupancy stops at 2 (PCs 0, 4).
  - `Address` holds at 8 in HOLD.
  - On release, the pop order is 0, 4, then 8 (F84103EB).
- Redirect with `RedirectPC`=0x2B while the FIFO holds 2 entries. Require:
  - `InstrValid`=0 the next cycle.
  - `Address`=0x28.
  - First new output is 17FFFFFD / `InstrPC` 0x28.
- Redirect in the same cycle as a full-FIFO pop and a would-be push. Require:
  - FIFO empty afterward.
  - No stale PC ever appears at `InstrPC`.
- `RESET_PC`=64'hFFFF_FFFF_FFFF_FFFC, `WAIT_CYCLES`=1. Require:
  - Second fetch `Address`=0.
  - `InstrPC` sequence ...FFC, 0.
- Assert `resetl` low mid-wait while in HOLD. Require:
  - All outputs return to reset values immediately, without waiting for a clock edge.
  - Fetch restarts at `RESET_PC`.
